// File: rtl/mc_control_if.sv
// ------------------------------------------------------------------
// mc_control_if : IR fields, memory handshake and control outputs.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       memready;

  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic [1:0] alusrcb;
  logic [2:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic       aluopandi;
  logic       aluopBlez;
  logic       illegal;
  logic [4:0] state;

  modport master (
    output op, funct, memready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
           alusrca, memtoreg, regdst, alusrcb, pcsource, aluop1, aluop0,
           aluopandi, aluopBlez, illegal, state
  );

  modport slave (
    input  op, funct, memready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
           alusrca, memtoreg, regdst, alusrcb, pcsource, aluop1, aluop0,
           aluopandi, aluopBlez, illegal, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_control.sv
// ------------------------------------------------------------------
// mc_control : multicycle MIPS main-control FSM with memory-ready stalls.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mc_control (
  input  wire logic   clk,
  input  wire logic   reset,
  mc_control_if.slave bus
);

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,  S_MEMWR  = 5'd5,  S_RTEX   = 5'd6,  S_RTWB   = 5'd7,
    S_BEQEX  = 5'd8,  S_BLEZEX = 5'd9,  S_ANDIEX = 5'd10, S_ANDIWB = 5'd11,
    S_JUMP   = 5'd12, S_JALR   = 5'd13, S_JMOREX = 5'd14, S_JMORRD = 5'd15,
    S_JMORWB = 5'd16
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic [1:0] alusrcb;
    logic [2:0] pcsource;
    logic       aluop1;
    logic       aluop0;
    logic       aluopandi;
    logic       aluopblez;
  } ctl_t;

  state_t r_state;
  ctl_t   r_ctl;
  state_t w_next;
  state_t w_dispatch;
  logic   w_on;
  logic   w_fetch;
  logic   w_illegal;

  function automatic state_t f_dispatch(input logic [5:0] op, input logic [5:0] funct);
    f_dispatch = S_FETCH;
    case (op)
      6'b100011, 6'b101011: f_dispatch = S_MEMADR;
      6'b000100:            f_dispatch = S_BEQEX;
      6'b000110:            f_dispatch = S_BLEZEX;
      6'b001100:            f_dispatch = S_ANDIEX;
      6'b000010:            f_dispatch = S_JUMP;
      6'b000000: begin
        case (funct)
          6'b001001: f_dispatch = S_JALR;
          6'b100101: f_dispatch = S_JMOREX;
          6'b100000, 6'b100010, 6'b100100, 6'b101010, 6'b000010:
                     f_dispatch = S_RTEX;
          default:   f_dispatch = S_FETCH;
        endcase
      end
      default:              f_dispatch = S_FETCH;
    endcase
  endfunction

  // Control word for the state about to be entered; registered alongside the state.
  function automatic ctl_t f_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 2'b01; end
      S_MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_RTEX:   begin c.alusrca = 1'b1; c.aluop1 = 1'b1; end
      S_RTWB:   begin c.regwrite = 1'b1; c.regdst = 2'b01; end
      S_BEQEX:  begin c.alusrca = 1'b1; c.aluop0 = 1'b1; c.pcwritecond = 1'b1; c.pcsource = 3'b001; end
      S_BLEZEX: begin c.alusrca = 1'b1; c.aluopblez = 1'b1; c.pcwritecond = 1'b1; c.pcsource = 3'b001; end
      S_ANDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluopandi = 1'b1; end
      S_ANDIWB: c.regwrite = 1'b1;
      S_JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 3'b010; end
      S_JALR:   begin c.regwrite = 1'b1; c.regdst = 2'b01; c.memtoreg = 2'b10;
                      c.pcwrite = 1'b1; c.pcsource = 3'b011; end
      S_JMOREX: begin c.alusrca = 1'b1; c.aluop1 = 1'b1; end
      S_JMORRD: begin c.memread = 1'b1; c.iord = 1'b1; end
      S_JMORWB: begin c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10;
                      c.pcwrite = 1'b1; c.pcsource = 3'b100; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_dispatch = f_dispatch(bus.op, bus.funct);
    w_next     = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_dispatch;
      S_MEMADR: w_next = (bus.op == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.memready ? S_FETCH : S_MEMWR;
      S_RTEX:   w_next = S_RTWB;
      S_ANDIEX: w_next = S_ANDIWB;
      S_JMOREX: w_next = S_JMORRD;
      S_JMORRD: w_next = bus.memready ? S_JMORWB : S_JMORRD;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctl   <= f_ctl(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctl   <= f_ctl(w_next);
    end
  end

  // Reset and any unreachable code blank every control output.
  assign w_on      = !reset && (r_state <= S_JMORWB);
  assign w_fetch   = (r_state == S_FETCH);
  assign w_illegal = (r_state == S_DECODE) && (w_dispatch == S_FETCH);

  assign bus.pcwrite     = w_on & r_ctl.pcwrite & (!w_fetch | bus.memready);
  assign bus.irwrite     = w_on & w_fetch & bus.memready;
  assign bus.pcwritecond = w_on & r_ctl.pcwritecond;
  assign bus.iord        = w_on & r_ctl.iord;
  assign bus.memread     = w_on & r_ctl.memread;
  assign bus.memwrite    = w_on & r_ctl.memwrite;
  assign bus.regwrite    = w_on & r_ctl.regwrite;
  assign bus.alusrca     = w_on & r_ctl.alusrca;
  assign bus.memtoreg    = w_on ? r_ctl.memtoreg : 2'b00;
  assign bus.regdst      = w_on ? r_ctl.regdst   : 2'b00;
  assign bus.alusrcb     = w_on ? r_ctl.alusrcb  : 2'b00;
  assign bus.pcsource    = w_on ? r_ctl.pcsource : 3'b000;
  assign bus.aluop1      = w_on & r_ctl.aluop1;
  assign bus.aluop0      = w_on & r_ctl.aluop0;
  assign bus.aluopandi   = w_on & r_ctl.aluopandi;
  assign bus.aluopBlez   = w_on & r_ctl.aluopblez;
  assign bus.illegal     = w_on & w_illegal;
  assign bus.state       = reset ? 5'd0 : r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ------------------------------------------------------------------
// tb_mc_control : randomized scoreboard bench for mc_control.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mc_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  st;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int   path[$];
  int   checks = 0;
  int   errors = 0;

  logic [21:0] act;
  assign act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.regwrite, bus.alusrca, bus.memtoreg, bus.regdst,
                bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0, bus.aluopandi,
                bus.aluopBlez, bus.illegal};

  // Per-state output table, same bit order as act.
  function automatic logic [21:0] model_out(input int s, input bit mr, input bit ill);
    logic pw, pwc, iord, mrd, mw, irw, rw, asa, a1, a0, aa, ab;
    logic [1:0] m2r, rd, asb;
    logic [2:0] ps;
    {pw, pwc, iord, mrd, mw, irw, rw, asa, a1, a0, aa, ab} = '0;
    m2r = 2'b00; rd = 2'b00; asb = 2'b00; ps = 3'b000;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; a1 = 1; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; a0 = 1; pwc = 1; ps = 3'b001; end
      9:  begin asa = 1; ab = 1; pwc = 1; ps = 3'b001; end
      10: begin asa = 1; asb = 2'b10; aa = 1; end
      11: rw = 1;
      12: begin pw = 1; ps = 3'b010; end
      13: begin rw = 1; rd = 2'b01; m2r = 2'b10; pw = 1; ps = 3'b011; end
      14: begin asa = 1; a1 = 1; end
      15: begin mrd = 1; iord = 1; end
      16: begin rw = 1; rd = 2'b10; m2r = 2'b10; pw = 1; ps = 3'b100; end
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mw, irw, rw, asa, m2r, rd, asb, ps, a1, a0, aa, ab, ill};
  endfunction

  // State walk of one instruction, derived from its opcode class.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    path = {0, 1};
    if (op == 6'b100011)      path = {0, 1, 2, 3, 4};
    else if (op == 6'b101011) path = {0, 1, 2, 5};
    else if (op == 6'b000100) path = {0, 1, 8};
    else if (op == 6'b000110) path = {0, 1, 9};
    else if (op == 6'b001100) path = {0, 1, 10, 11};
    else if (op == 6'b000010) path = {0, 1, 12};
    else if (op == 6'b000000) begin
      if (fn == 6'b001001)      path = {0, 1, 13};
      else if (fn == 6'b100101) path = {0, 1, 14, 15, 16};
      else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b101010, 6'b000010})
        path = {0, 1, 6, 7};
    end
  endtask

  task automatic drive(input bit r, input logic [5:0] op, input logic [5:0] fn,
                       input bit mr, input logic [4:0] st, input logic [21:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = r;
    bus.op       = op;
    bus.funct    = fn;
    bus.memready = mr;
    e.st = r ? 5'd0 : st;
    e.v  = r ? 22'd0 : v;
    q.push_back(e);
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input int wf, input int wm, input int rst_at);
    int st[$];
    bit mr[$];
    bit ill[$];
    build_path(op, fn);
    foreach (path[i]) begin
      int s;
      s = path[i];
      if (s inside {0, 3, 5, 15}) begin
        int w;
        w = (s == 0) ? wf : wm;
        for (int k = 0; k < w; k++) begin
          st.push_back(s); mr.push_back(1'b0); ill.push_back(1'b0);
        end
        st.push_back(s); mr.push_back(1'b1); ill.push_back(1'b0);
      end else begin
        st.push_back(s);
        mr.push_back(1'($urandom_range(0, 1)));
        ill.push_back(s == 1 && path.size() == 2);
      end
    end
    for (int i = 0; i < st.size(); i++) begin
      if (i == rst_at) begin
        int n;
        n = $urandom_range(1, 2);
        for (int k = 0; k < n; k++) drive(1'b1, op, fn, 1'($urandom_range(0, 1)), 5'd0, 22'd0);
        return;
      end
      drive(1'b0, op, fn, mr[i], 5'(st[i]), model_out(st[i], mr[i], ill[i]));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (bus.state !== e.st) begin
          errors++;
          $display("FAIL state @%0t: got %0d expected %0d", $time, bus.state, e.st);
        end
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL outputs @%0t (state %0d): got %06h expected %06h", $time, e.st, act, e.v);
        end
        checks++;
        if (bus.pcwrite && bus.pcwritecond) begin
          errors++;
          $display("FAIL pc_excl @%0t: got pcwrite=1 pcwritecond=1 expected not both", $time);
        end
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    int sel, rat;
    bus.op = 6'd0; bus.funct = 6'd0; bus.memready = 1'b1;
    drive(1'b1, 6'd0, 6'd0, 1'b1, 5'd0, 22'd0);
    drive(1'b1, 6'd0, 6'd0, 1'b1, 5'd0, 22'd0);
    do_instr(6'b100011, 6'd0,      0, 2, -1);  // lw, 2 stall cycles in MEMRD
    do_instr(6'b000000, 6'b100010, 0, 0, -1);  // sub
    do_instr(6'b000110, 6'd0,      1, 0, -1);  // blez
    do_instr(6'b001100, 6'd0,      0, 0, -1);  // andi
    do_instr(6'b000000, 6'b100101, 0, 1, -1);  // jmor
    do_instr(6'b000000, 6'b001001, 0, 0, -1);  // jalr
    do_instr(6'b111111, 6'd0,      0, 0, -1);  // illegal
    do_instr(6'b000100, 6'd0,      0, 0, -1);  // beq
    do_instr(6'b000010, 6'd0,      0, 0, -1);  // j
    do_instr(6'b101011, 6'd0,      0, 0, 3);   // sw, reset lands in MEMWR
    do_instr(6'b101011, 6'd0,      0, 1, -1);  // sw

    repeat (300) begin
      sel = $urandom_range(0, 15);
      op  = 6'd0;
      fn  = 6'($urandom);
      case (sel)
        0:  op = 6'b100011;
        1:  op = 6'b101011;
        2:  op = 6'b000100;
        3:  op = 6'b000110;
        4:  op = 6'b001100;
        5:  op = 6'b000010;
        6:  fn = 6'b001001;
        7:  fn = 6'b100101;
        8:  fn = 6'b100000;
        9:  fn = 6'b100010;
        10: fn = 6'b100100;
        11: fn = 6'b101010;
        12: fn = 6'b000010;
        13: ;
        default: op = 6'($urandom);
      endcase
      rat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
      do_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rat);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multicycle main-control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback over multiple clocks. It drives the ALU-op bits consumed by the ALU control decoder (`aluop1`, `aluop0`, `aluopandi`, `aluopBlez`). It also produces every datapath mux select and write enable, including the custom `jalr` and `jmor` R-type instructions, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- `clk` in 1: single clock, all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction opcode from IR.
- `funct` in 6: function field from IR.
- `memready` in 1: memory access completes this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`, `regwrite`, `alusrca` out 1 each: datapath enables/selects.
- `memtoreg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `regdst` out 2: 00 rt, 01 rd, 10 $31.
- `alusrcb` out 2: 00 B, 01 const 4, 10 imm, 11 imm<<2.
- `pcsource` out 3: 000 ALU, 001 ALUOut, 010 jump target, 011 A, 100 MDR.
- `aluop1`, `aluop0`, `aluopandi`, `aluopBlez` out 1 each: to ALU control.
- `illegal` out 1: one-cycle pulse on undecodable instruction.
- `state` out 5: current state, for debug.

## Operation
- Decided: one clock (`clk`); `reset` synchronous, active-high.
- States and codes, with the outputs each asserts. Unlisted outputs are 0.
  - FETCH(0): memread=1, alusrcb=01. irwrite=memready, pcwrite=memready. Stay while !memready.
  - DECODE(1): alusrcb=11. Next state by op/funct.
  - MEMADR(2): alusrca=1, alusrcb=10. Go to MEMRD if op=100011, else MEMWR.
  - MEMRD(3): memread=1, iord=1. Stay while !memready. MEMRD→MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=01, regdst=00.
  - MEMWR(5): memwrite=1, iord=1. Stay while !memready.
  - RTEX(6): alusrca=1, aluop1=1. RTEX→RTWB.
  - RTWB(7): regwrite=1, regdst=01.
  - BEQEX(8): alusrca=1, aluop0=1, pcwritecond=1, pcsource=001.
  - BLEZEX(9): alusrca=1, aluopBlez=1, pcwritecond=1, pcsource=001.
  - ANDIEX(10): alusrca=1, alusrcb=10, aluopandi=1. ANDIEX→ANDIWB.
  - ANDIWB(11): regwrite=1, regdst=00.
  - JUMP(12): pcwrite=1, pcsource=010.
  - JALR(13): regwrite=1, regdst=01, memtoreg=10, pcwrite=1, pcsource=011.
  - JMOREX(14): alusrca=1, aluop1=1 (funct 100101 decodes as OR). JMOREX→JMORRD.
  - JMORRD(15): memread=1, iord=1. Stay while !memready. JMORRD→JMORWB.
  - JMORWB(16): regwrite=1, regdst=10, memtoreg=10, pcwrite=1, pcsource=100.
- States 4, 5, 7, 8, 9, 11, 12, 13 and 16 return to FETCH.
- DECODE dispatch:
  - op 100011 or 101011 → MEMADR.
  - op 000100 → BEQEX.
  - op 000110 → BLEZEX.
  - op 001100 → ANDIEX.
  - op 000010 → JUMP.
  - op 000000: funct 001001 → JALR, funct 100101 → JMOREX, funct in {100000, 100010, 100100, 101010, 000010} → RTEX.
  - Anything else → FETCH with `illegal`=1 for that DECODE cycle.
- In FETCH, `irwrite` and `pcwrite` are combinational ANDs with `memready`. All other outputs are a pure function of `state`.
- Codes 17–31 are unreachable. If entered, next state is FETCH and all outputs are 0.

## Timing
- Reset: while `reset`=1 at an edge, state becomes FETCH(0). Every output is combinationally 0 while `reset`=1, including `state`=0 and `illegal`=0. The first FETCH cycle is the cycle after `reset` is sampled low.
- A reset mid-instruction abandons it. No write enable is asserted in the reset cycle.
- Minimum cycles per instruction, with `memready` held 1:
  - lw 5, sw 4, R-type 4, andi 4, jmor 5.
  - beq 3, blez 3, j 3, jalr 3.
  - illegal 2.
- Each wait cycle with `memready`=0 in FETCH, MEMRD, MEMWR or JMORRD adds exactly one cycle. During a wait all outputs of that state hold steady, except the gated `irwrite`/`pcwrite`.
- `memready` is ignored in all other states.
- `pcwritecond` is never asserted in the same cycle as `pcwrite`.

## Test plan
- Reset with `memready`=1, release → cycle 1 `state`=0, `memread`=1, `irwrite`=1, `pcwrite`=1. During reset all outputs are 0.
- lw (op 100011), `memready` low 2 cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0. In state 4: `regwrite`=1, `memtoreg`=01.
- R-type sub (funct 100010) → states 0,1,6,7. In state 6: `aluop1`=1. In state 7: `regdst`=01, `regwrite`=1.
- blez (op 000110) → state 9 with `aluopBlez`=1, `pcwritecond`=1, `pcsource`=001. andi (op 001100) → state 10 with `aluopandi`=1, then 11.
- jmor (op 0, funct 100101) → states 14, 15, 16. In state 16: `regdst`=10, `memtoreg`=10, `pcsource`=100, `pcwrite`=1. jalr (funct 001001) → state 13 with `pcsource`=011.
- Illegal op 111111 → DECODE with `illegal`=1, then FETCH. `reset` asserted during MEMWR → next state 0 and `memwrite`=0 in the reset cycle.
